microprocessor_p: RTL

Parametrised successor to the 4-bit nibble processor. Data width, program-address width and call-stack depth are generics. Adds a registered two-stage fetch/execute pipeline with branch squash, a load stall for synchronous data memory, CALL/RET with a hardware return stack, and a sticky stack-error flag. Program and data memories are external, synchronous-read, clocked on the rising edge of clk.

---
 rtl/microprocessor_p.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/microprocessor_p.sv
// rtl/microprocessor_p.sv - parametrised two-stage nibble-style processor with return stack
module microprocessor_p #(
    parameter int DATA_W      = 4,
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] pm_address,
    input  logic [DATA_W+6:0] pm_data,
    output logic [DATA_W-1:0] dm_address,
    output logic [DATA_W-1:0] dm_wdata,
    output logic              dm_wren,
    input  logic [DATA_W-1:0] dm_rdata,
    input  logic [DATA_W-1:0] i_pins,
    output logic [DATA_W-1:0] o_reg,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W+6:0] ir,
    output logic              zero_flag,
    output logic              stack_err
);
    localparam int IW    = DATA_W + 7;
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = $clog2(STACK_DEPTH);

    localparam logic [3:0] OP_LDI  = 4'h0;
    localparam logic [3:0] OP_MOV  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_INC  = 4'h6;
    localparam logic [3:0] OP_LD   = 4'h7;
    localparam logic [3:0] OP_ST   = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_JNZ  = 4'hA;
    localparam logic [3:0] OP_CALL = 4'hB;
    localparam logic [3:0] OP_RET  = 4'hC;

    typedef enum logic {S_RUN, S_LOAD} state_e;

    state_e                          state_q, state_d;
    logic [ADDR_W-1:0]               pc_q, pc_d;
    logic                            fetch_valid_q, fetch_valid_d;
    logic [IW-1:0]                   ld_ir_q, ld_ir_d;
    logic [7:0][DATA_W-1:0]          regs_q, regs_d;
    logic                            zero_q, zero_d;
    logic                            err_q, err_d;
    logic [STACK_DEPTH-1:0][ADDR_W-1:0] stack_q, stack_d;
    logic [SP_W-1:0]                 sp_q, sp_d;

    logic [3:0]        op;
    logic [2:0]        dst;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] x_opnd, y_opnd, alu, src;
    logic [ADDR_W-1:0] target;
    logic [IDX_W-1:0]  push_idx, pop_idx;
    logic              wren;

    always_comb begin
        op       = pm_data[IW-1 -: 4];
        dst      = pm_data[IW-5 -: 3];
        imm      = pm_data[DATA_W-1:0];
        x_opnd   = dst[0] ? regs_q[1] : regs_q[0];
        y_opnd   = dst[1] ? regs_q[3] : regs_q[2];
        target   = ADDR_W'(imm);
        src      = (imm[2:0] == 3'd7) ? i_pins : regs_q[imm[2:0]];
        push_idx = IDX_W'(sp_q);
        pop_idx  = IDX_W'(sp_q - SP_W'(1));

        case (op)
            OP_ADD:  alu = x_opnd + y_opnd;
            OP_SUB:  alu = x_opnd - y_opnd;
            OP_AND:  alu = x_opnd & y_opnd;
            OP_XOR:  alu = x_opnd ^ y_opnd;
            default: alu = '0;
        endcase

        pc_d          = pc_q + ADDR_W'(1);
        fetch_valid_d = 1'b1;
        state_d       = S_RUN;
        ld_ir_d       = ld_ir_q;
        regs_d        = regs_q;
        zero_d        = zero_q;
        err_d         = err_q;
        stack_d       = stack_q;
        sp_d          = sp_q;
        wren          = 1'b0;

        // The word on pm_data during the load's second cycle is the next
        // instruction, fetched while pc was held; it executes next cycle.
        if (state_q == S_LOAD) begin
            regs_d[5] = dm_rdata;
        end else if (fetch_valid_q) begin
            case (op)
                OP_LDI: regs_d[dst] = imm;
                OP_MOV: regs_d[dst] = src;
                OP_ADD, OP_SUB, OP_AND, OP_XOR: begin
                    regs_d[4] = alu;
                    zero_d    = (alu == '0);
                end
                OP_INC: regs_d[6] = regs_q[6] + DATA_W'(1);
                OP_LD: begin
                    pc_d    = pc_q;
                    state_d = S_LOAD;
                    ld_ir_d = pm_data;
                end
                OP_ST:  wren = 1'b1;
                OP_JMP: begin
                    pc_d          = target;
                    fetch_valid_d = 1'b0;
                end
                OP_JNZ: begin
                    if (!zero_q) begin
                        pc_d          = target;
                        fetch_valid_d = 1'b0;
                    end
                end
                OP_CALL: begin
                    pc_d          = target;
                    fetch_valid_d = 1'b0;
                    if (sp_q == SP_W'(STACK_DEPTH)) begin
                        err_d = 1'b1;
                    end else begin
                        stack_d[push_idx] = pc_q;
                        sp_d              = sp_q + SP_W'(1);
                    end
                end
                OP_RET: begin
                    if (sp_q == '0) begin
                        err_d = 1'b1;
                    end else begin
                        pc_d          = stack_q[pop_idx];
                        fetch_valid_d = 1'b0;
                        sp_d          = sp_q - SP_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_RUN;
            pc_q          <= '0;
            fetch_valid_q <= 1'b0;
            ld_ir_q       <= '0;
            regs_q        <= '0;
            zero_q        <= 1'b0;
            err_q         <= 1'b0;
            stack_q       <= '0;
            sp_q          <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            ld_ir_q       <= ld_ir_d;
            regs_q        <= regs_d;
            zero_q        <= zero_d;
            err_q         <= err_d;
            stack_q       <= stack_d;
            sp_q          <= sp_d;
        end
    end

    assign pm_address = pc_q;
    assign pc         = pc_q;
    assign dm_address = regs_q[6];
    assign dm_wdata   = regs_q[dst];
    assign dm_wren    = wren;
    assign o_reg      = regs_q[7];
    assign zero_flag  = zero_q;
    assign stack_err  = err_q;
    assign ir         = (state_q == S_LOAD) ? ld_ir_q : (fetch_valid_q ? pm_data : '0);

endmodule
